// File: rtl/moore_seq_detector.sv
// Serial sequence detector with registered (Moore) match output.
// Supports overlap policy, sticky/pulse output, sample enable and saturating match count.
module moore_seq_detector #(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter bit             STICKY  = 1'b0,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             R,
    input  logic             w,
    input  logic             en,
    input  logic             clr,
    output logic             Z,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic [LEN-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              z_q, z_d;

    // Shift the new bit in as the LSB; the extended vector keeps LEN=1 legal.
    logic [LEN:0]      hist_ext;
    logic [LEN-1:0]    hist_sh;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    assign hist_ext = {hist_q, w};
    assign hist_sh  = hist_ext[LEN-1:0];
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    // Next-state: clear beats enable; a match only counts once LEN real samples exist.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        z_d    = STICKY ? z_q : 1'b0;
        match  = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            z_d    = 1'b0;
        end else if (en) begin
            hist_d = hist_sh;
            fill_d = fill_inc;
            match  = (fill_inc == FILL_FULL) && (hist_sh == PATTERN);
            if (match) begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!OVERLAP) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
            z_d = STICKY ? (z_q | match) : match;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge Clock or posedge R) begin
        if (R) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

    assign Z           = z_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Randomized and directed bench for moore_seq_detector across five parameter sets.
// A queue-based reference model tracks every instance from the same input stream.
module tb_moore_seq_detector;

    localparam int NCFG = 5;

    logic Clock = 1'b0;
    logic R     = 1'b1;
    logic w     = 1'b0;
    logic en    = 1'b0;
    logic clr   = 1'b0;

    logic [NCFG-1:0] z;
    logic [7:0] c0, c1, c2, c4;
    logic [1:0] c3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    moore_seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1),
                         .STICKY(1'b0), .CNT_W(8)) u_basic (
        .Clock(Clock), .R(R), .w(w), .en(en), .clr(clr),
        .Z(z[0]), .match_count(c0));

    moore_seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0),
                         .STICKY(1'b0), .CNT_W(8)) u_novl (
        .Clock(Clock), .R(R), .w(w), .en(en), .clr(clr),
        .Z(z[1]), .match_count(c1));

    moore_seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1),
                         .STICKY(1'b1), .CNT_W(8)) u_stky (
        .Clock(Clock), .R(R), .w(w), .en(en), .clr(clr),
        .Z(z[2]), .match_count(c2));

    moore_seq_detector #(.LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1),
                         .STICKY(1'b0), .CNT_W(2)) u_sat (
        .Clock(Clock), .R(R), .w(w), .en(en), .clr(clr),
        .Z(z[3]), .match_count(c3));

    moore_seq_detector #(.LEN(4), .PATTERN(4'b0001), .OVERLAP(1'b1),
                         .STICKY(1'b0), .CNT_W(8)) u_lz (
        .Clock(Clock), .R(R), .w(w), .en(en), .clr(clr),
        .Z(z[4]), .match_count(c4));

    // Reference model: samples since the last flush, kept as a queue per config.
    int p_len [NCFG] = '{4, 4, 4, 1, 4};
    int p_pat [NCFG] = '{13, 13, 13, 1, 1};
    bit p_ovl [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit p_stk [NCFG] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int p_max [NCFG] = '{255, 255, 255, 3, 255};

    bit hq [NCFG][$];
    int m_cnt [NCFG];
    bit m_z [NCFG];

    task automatic mdl_reset();
        for (int k = 0; k < NCFG; k++) begin
            hq[k].delete();
            m_cnt[k] = 0;
            m_z[k]   = 1'b0;
        end
    endtask

    task automatic mdl_edge();
        for (int k = 0; k < NCFG; k++) begin
            if (R || clr) begin
                hq[k].delete();
                m_cnt[k] = 0;
                m_z[k]   = 1'b0;
            end else if (en) begin
                bit m;
                int v;
                hq[k].push_back(w);
                if (hq[k].size() > p_len[k]) void'(hq[k].pop_front());
                v = 0;
                foreach (hq[k][i]) v = (v << 1) | int'(hq[k][i]);
                m = (hq[k].size() == p_len[k]) && (v == p_pat[k]);
                if (m) begin
                    if (m_cnt[k] < p_max[k]) m_cnt[k]++;
                    if (!p_ovl[k]) hq[k].delete();
                end
                m_z[k] = p_stk[k] ? (m_z[k] | m) : m;
            end else begin
                m_z[k] = p_stk[k] ? m_z[k] : 1'b0;
            end
        end
    endtask

    always @(posedge Clock) mdl_edge();

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int obs [NCFG];
        obs[0] = int'(c0);
        obs[1] = int'(c1);
        obs[2] = int'(c2);
        obs[3] = int'(c3);
        obs[4] = int'(c4);
        for (int k = 0; k < NCFG; k++) begin
            chk($sformatf("z%0d", k), int'(z[k]), int'(m_z[k]));
            chk($sformatf("cnt%0d", k), obs[k], m_cnt[k]);
        end
    endtask

    task automatic step(input bit wi, input bit ei, input bit ci);
        @(negedge Clock);
        w   = wi;
        en  = ei;
        clr = ci;
        @(posedge Clock);
        #1;
        check_all();
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic pulse_rst();
        @(negedge Clock);
        w   = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        #2;
        R = 1'b1;
        mdl_reset();
        #1;
        check_all();
        chk("async_rst_z", int'(z), 0);
        #1;
        R = 1'b0;
    endtask

    initial begin
        mdl_reset();
        for (int i = 0; i < 3; i++) step(i[0], 1'b1, 1'b0);
        chk("rst_hold_z", int'(z), 0);
        @(negedge Clock);
        R = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        chk("idle_z0", int'(z[0]), 0);

        feed(16'b1101, 4);
        chk("basic_z", int'(z[0]), 1);
        chk("basic_cnt", int'(c0), 1);
        feed(16'b101, 3);
        chk("basic_cnt2", int'(c0), 2);
        chk("novl_cnt", int'(c1), 1);
        feed(16'b11011101, 8);
        chk("novl_cnt3", int'(c1), 3);

        pulse_rst();
        feed(16'b1101, 4);
        chk("stky_z", int'(z[2]), 1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        chk("stky_hold", int'(z[2]), 1);
        pulse_rst();
        feed(16'b1101, 4);
        chk("stky_z2", int'(z[2]), 1);
        chk("stky_cnt", int'(c2), 1);

        pulse_rst();
        feed(16'b11, 2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        feed(16'b01, 2);
        chk("en_gap_z", int'(z[0]), 1);
        chk("en_gap_cnt", int'(c0), 1);

        pulse_rst();
        feed(16'b110, 3);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("clr_z", int'(z[0]), 0);
        chk("clr_cnt", int'(c0), 0);

        pulse_rst();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        chk("sat_cnt", int'(c3), 3);
        chk("sat_z", int'(z[3]), 1);

        pulse_rst();
        step(1'b1, 1'b1, 1'b0);
        chk("lz_first", int'(z[4]), 0);
        feed(16'b0001, 4);
        chk("lz_match", int'(z[4]), 1);

        pulse_rst();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_rst();
            end else begin
                step(1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 8,
                     $urandom_range(0, 99) < 3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
